// File: rtl/expansion_shiftreg_ctrl_if.sv
// expansion_shiftreg_ctrl_if
//
// Groups every non-clock signal of the shift-register transfer scheduler.
//   Host side  : data_out, wr_req (to controller); data_in, in_valid,
//                frame_cnt, busy (from controller)
//   Engine side: eng_busy, eng_done, eng_in (to controller);
//                eng_start, eng_out (from controller)
//   Errors     : err_clr (to controller); err_timeout (from controller)
// Modport slave is the controller's view; master is the host/engine view.
interface expansion_shiftreg_ctrl_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] data_out;
    logic             wr_req;
    logic [WIDTH-1:0] data_in;
    logic             in_valid;
    logic [15:0]      frame_cnt;
    logic             busy;
    logic             eng_start;
    logic [WIDTH-1:0] eng_out;
    logic             eng_busy;
    logic             eng_done;
    logic [WIDTH-1:0] eng_in;
    logic             err_timeout;
    logic             err_clr;

    modport slave (
        input  data_out, wr_req, eng_busy, eng_done, eng_in, err_clr,
        output data_in, in_valid, frame_cnt, busy, eng_start, eng_out, err_timeout
    );

    modport master (
        output data_out, wr_req, eng_busy, eng_done, eng_in, err_clr,
        input  data_in, in_valid, frame_cnt, busy, eng_start, eng_out, err_timeout
    );
endinterface

// File: rtl/expansion_shiftreg_ctrl.sv
// expansion_shiftreg_ctrl
//
// Transfer scheduler for the shift-register I/O expansion engine. A frame is
// launched on a periodic refresh expiry or on a host write request. The output
// word is frozen into eng_out when a frame is launched and the input word is
// published as a single snapshot (data_in + one-cycle in_valid) when the
// engine reports completion.
//
// Ports:
//   clk    in  system clock
//   rst_n  in  asynchronous active-low reset
//   bus    expansion_shiftreg_ctrl_if.slave
//          host  : data_out, wr_req -> ; data_in, in_valid, frame_cnt, busy <-
//          engine: eng_busy, eng_done, eng_in -> ; eng_start, eng_out <-
//          errors: err_clr -> ; err_timeout <-
//
// Optional feature: define SHIFTREG_WATCHDOG_EN to enable the WAIT-state
// watchdog (TIMEOUT cycles from eng_start) and the sticky err_timeout flag.
// Without it err_timeout is tied low and err_clr is ignored.
module expansion_shiftreg_ctrl #(
    parameter int WIDTH   = 8,
    parameter int REFRESH = 1000,
    parameter int TIMEOUT = 4096
) (
    input  logic                     clk,
    input  logic                     rst_n,
    expansion_shiftreg_ctrl_if.slave bus
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] START = 2'd1;
    localparam logic [1:0] WAIT  = 2'd2;
    localparam logic [1:0] LATCH = 2'd3;

    localparam int               REF_W    = (REFRESH > 1) ? $clog2(REFRESH) : 1;
    localparam logic [REF_W-1:0] REF_LAST = REF_W'(REFRESH - 1);

    logic [1:0]       state;
    logic [REF_W-1:0] ref_cnt;
    logic             pending;
    logic             eng_start_q;
    logic             busy_q;
    logic             in_valid_q;
    logic [WIDTH-1:0] eng_out_q;
    logic [WIDTH-1:0] data_in_q;
    logic [15:0]      frame_cnt_q;

    logic trigger;
    logic frame_done;
    logic wd_expire;

    // Any of the three launch sources; a simultaneous write and refresh
    // expiry still launch only one frame since both are consumed together.
    assign trigger    = bus.wr_req || pending || (ref_cnt == REF_LAST);
    // Completion is only honoured while waiting on the engine.
    assign frame_done = (state == WAIT) && bus.eng_done;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            ref_cnt     <= '0;
            pending     <= 1'b0;
            eng_start_q <= 1'b0;
            busy_q      <= 1'b0;
            in_valid_q  <= 1'b0;
            eng_out_q   <= '0;
            data_in_q   <= '0;
            frame_cnt_q <= '0;
        end else begin
            eng_start_q <= 1'b0;
            in_valid_q  <= 1'b0;
            // Written every cycle so the count is always a function of its
            // own previous value.
            frame_cnt_q <= frame_cnt_q + 16'(frame_done);

            // Saturating at the last value keeps a refresh that fell due
            // mid-frame armed until the controller is back in IDLE.
            if (ref_cnt != REF_LAST) begin
                ref_cnt <= ref_cnt + REF_W'(1);
            end

            if (bus.wr_req && (state != IDLE)) begin
                pending <= 1'b1;
            end

            case (state)
                IDLE: begin
                    if (trigger) begin
                        eng_out_q   <= bus.data_out;
                        pending     <= 1'b0;
                        eng_start_q <= 1'b1;
                        busy_q      <= 1'b1;
                        ref_cnt     <= '0;
                        state       <= START;
                    end
                end
                START: begin
                    state <= WAIT;
                end
                WAIT: begin
                    // Snapshot is published on the edge that sees eng_done so
                    // data_in/in_valid/frame_cnt all move together in LATCH.
                    if (bus.eng_done) begin
                        data_in_q  <= bus.eng_in;
                        in_valid_q <= 1'b1;
                        busy_q     <= 1'b0;
                        state      <= LATCH;
                    end else if (wd_expire) begin
                        busy_q <= 1'b0;
                        state  <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef SHIFTREG_WATCHDOG_EN
    localparam int              WD_W    = $clog2(TIMEOUT + 1);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT);

    logic [WD_W-1:0] wd_cnt;
    logic            err_q;

    // Counter is 0 in the START cycle, so it equals the number of cycles
    // elapsed since eng_start.
    assign wd_expire = (state == WAIT) && !bus.eng_done && (wd_cnt == WD_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wd_cnt <= '0;
            err_q  <= 1'b0;
        end else begin
            if (state == IDLE) begin
                wd_cnt <= '0;
            end else if (wd_cnt != WD_LAST) begin
                wd_cnt <= wd_cnt + WD_W'(1);
            end

            // A new timeout takes priority over a simultaneous clear.
            if (wd_expire) begin
                err_q <= 1'b1;
            end else if (bus.err_clr) begin
                err_q <= 1'b0;
            end
        end
    end

    assign bus.err_timeout = err_q;
`else
    logic unused_wd;

    assign wd_expire       = 1'b0;
    assign bus.err_timeout = 1'b0;
    assign unused_wd       = ^{bus.err_clr, 32'(TIMEOUT)};
`endif

    // eng_busy is informational only; completion is signalled by eng_done.
    logic unused_busy;
    assign unused_busy = bus.eng_busy;

    assign bus.eng_start = eng_start_q;
    assign bus.eng_out   = eng_out_q;
    assign bus.busy      = busy_q;
    assign bus.data_in   = data_in_q;
    assign bus.in_valid  = in_valid_q;
    assign bus.frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_expansion_shiftreg_ctrl.sv
// tb_expansion_shiftreg_ctrl
//
// Directed bench for expansion_shiftreg_ctrl with REFRESH=20, TIMEOUT=50.
// A small engine model answers eng_start with eng_done after eng_lat cycles
// (or never, when eng_hang is set). Inputs are driven and outputs sampled on
// the falling clock edge. Cycle numbers in comments (cN) count falling edges
// after the reset-release edge c0.
module tb_expansion_shiftreg_ctrl;
    localparam int WIDTH   = 8;
    localparam int REFRESH = 20;
    localparam int TIMEOUT = 50;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;

    logic [WIDTH-1:0] eng_word;
    int               eng_lat;
    logic             eng_hang;
    logic             stray_done;
    logic             model_done;
    logic             model_running;
    int               rem;

    expansion_shiftreg_ctrl_if #(.WIDTH(WIDTH)) bif ();

    expansion_shiftreg_ctrl #(
        .WIDTH  (WIDTH),
        .REFRESH(REFRESH),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bif.slave)
    );

    assign bif.eng_done = model_done | stray_done;
    assign bif.eng_in   = eng_word;
    assign bif.eng_busy = model_running;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Engine model
    initial begin
        model_done    = 1'b0;
        model_running = 1'b0;
        rem           = 0;
        forever begin
            @(negedge clk);
            model_done = 1'b0;
            if (rst_n !== 1'b1) begin
                model_running = 1'b0;
            end else if (bif.eng_start === 1'b1) begin
                model_running = 1'b1;
                rem = eng_lat;
            end else if (model_running) begin
                rem = rem - 1;
                if (rem == 0) begin
                    model_running = 1'b0;
                    model_done    = !eng_hang;
                end
            end
        end
    end

    task automatic apply_reset();
        rst_n        = 1'b0;
        bif.wr_req   = 1'b0;
        bif.err_clr  = 1'b0;
        stray_done   = 1'b0;
        eng_hang     = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic wait_start(input int max, output int n);
        n = 0;
        while (n < max) begin
            @(negedge clk);
            n++;
            if (bif.eng_start === 1'b1) return;
        end
        n = -1;
    endtask

    task automatic wait_valid(input int max, output int n);
        n = 0;
        while (n < max) begin
            @(negedge clk);
            n++;
            if (bif.in_valid === 1'b1) return;
        end
        n = -1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bif.data_out = 8'h5A;
        repeat (3) @(negedge clk);
        checks++; if (bif.data_in !== 8'h00) begin errors++; $display("FAIL reset_data_in: got %h want 00", bif.data_in); end
        checks++; if (bif.in_valid !== 1'b0) begin errors++; $display("FAIL reset_in_valid: got %b want 0", bif.in_valid); end
        checks++; if (bif.frame_cnt !== 16'h0000) begin errors++; $display("FAIL reset_frame_cnt: got %h want 0000", bif.frame_cnt); end
        checks++; if (bif.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", bif.busy); end
        checks++; if (bif.eng_start !== 1'b0) begin errors++; $display("FAIL reset_eng_start: got %b want 0", bif.eng_start); end
        checks++; if (bif.eng_out !== 8'h00) begin errors++; $display("FAIL reset_eng_out: got %h want 00", bif.eng_out); end
        checks++; if (bif.err_timeout !== 1'b0) begin errors++; $display("FAIL reset_err: got %b want 0", bif.err_timeout); end
        rst_n = 1'b1;
    endtask

    task automatic test_refresh();
        int n;
        int prev;
        eng_lat = 10;
        apply_reset();
        prev = cyc;
        for (int f = 0; f < 3; f++) begin
            eng_word = 8'h10 + 8'(f);
            wait_start(30, n);
            checks++; if (n < 0 || cyc - prev != 20) begin errors++; $display("FAIL refresh_period[%0d]: got %0d cycles want 20", f, (n < 0) ? -1 : cyc - prev); end
            prev = cyc;
            checks++; if (bif.busy !== 1'b1) begin errors++; $display("FAIL refresh_busy_hi[%0d]: got %b want 1", f, bif.busy); end
            wait_valid(20, n);
            checks++; if (n != 11) begin errors++; $display("FAIL refresh_valid_lat[%0d]: got %0d want 11", f, n); end
            checks++; if (bif.data_in !== 8'h10 + 8'(f)) begin errors++; $display("FAIL refresh_data_in[%0d]: got %h want %h", f, bif.data_in, 8'h10 + 8'(f)); end
            checks++; if (bif.frame_cnt !== 16'(f + 1)) begin errors++; $display("FAIL refresh_frame_cnt[%0d]: got %0d want %0d", f, bif.frame_cnt, f + 1); end
            checks++; if (bif.busy !== 1'b0) begin errors++; $display("FAIL refresh_busy_lo[%0d]: got %b want 0", f, bif.busy); end
            @(negedge clk);
            checks++; if (bif.in_valid !== 1'b0) begin errors++; $display("FAIL refresh_valid_pulse[%0d]: got %b want 0", f, bif.in_valid); end
        end
    endtask

    task automatic test_write();
        int n;
        eng_lat  = 3;
        eng_word = 8'h3C;
        apply_reset();
        repeat (2) @(negedge clk);                       // c2
        checks++; if (bif.eng_start !== 1'b0) begin errors++; $display("FAIL write_idle_start: got %b want 0", bif.eng_start); end
        bif.data_out = 8'hA5;
        bif.wr_req   = 1'b1;
        @(negedge clk);                                  // c3
        bif.wr_req   = 1'b0;
        bif.data_out = 8'h5A;
        checks++; if (bif.eng_start !== 1'b1) begin errors++; $display("FAIL write_start: got %b want 1", bif.eng_start); end
        checks++; if (bif.eng_out !== 8'hA5) begin errors++; $display("FAIL write_eng_out: got %h want a5", bif.eng_out); end
        checks++; if (bif.busy !== 1'b1) begin errors++; $display("FAIL write_busy: got %b want 1", bif.busy); end
        wait_valid(10, n);                               // done c6, valid c7
        checks++; if (n != 4) begin errors++; $display("FAIL write_valid_lat: got %0d want 4", n); end
        checks++; if (bif.data_in !== 8'h3C) begin errors++; $display("FAIL write_data_in: got %h want 3c", bif.data_in); end
        checks++; if (bif.frame_cnt !== 16'd1) begin errors++; $display("FAIL write_frame_cnt: got %0d want 1", bif.frame_cnt); end
        checks++; if (bif.eng_out !== 8'hA5) begin errors++; $display("FAIL write_eng_out_hold: got %h want a5", bif.eng_out); end
    endtask

    task automatic test_pending_back_to_back();
        int n;
        int cnt;
        eng_lat  = 10;
        eng_word = 8'h81;
        apply_reset();
        repeat (2) @(negedge clk);                       // c2
        bif.data_out = 8'h77;
        bif.wr_req   = 1'b1;
        @(negedge clk);                                  // c3 start
        bif.wr_req = 1'b0;
        repeat (2) @(negedge clk);                       // c5
        for (int i = 0; i < 3; i++) begin                // pulses at c5, c7, c9
            bif.data_out = 8'(i + 1);
            bif.wr_req   = 1'b1;
            @(negedge clk);
            bif.wr_req = 1'b0;
            @(negedge clk);
        end                                              // c11
        checks++; if (bif.eng_out !== 8'h77) begin errors++; $display("FAIL pend_eng_out_frozen: got %h want 77", bif.eng_out); end
        wait_valid(10, n);                               // done c13, valid c14
        checks++; if (n != 3) begin errors++; $display("FAIL pend_valid_lat: got %0d want 3", n); end
        checks++; if (bif.eng_out !== 8'h77) begin errors++; $display("FAIL pend_eng_out_at_valid: got %h want 77", bif.eng_out); end
        checks++; if (bif.data_in !== 8'h81) begin errors++; $display("FAIL pend_data_in: got %h want 81", bif.data_in); end
        eng_word = 8'h82;
        wait_start(5, n);                                // M+3 = c16
        checks++; if (n != 2) begin errors++; $display("FAIL pend_b2b_start: got %0d want 2", n); end
        checks++; if (bif.eng_out !== 8'h03) begin errors++; $display("FAIL pend_follow_eng_out: got %h want 03", bif.eng_out); end
        cnt = 0;
        repeat (19) begin                                // c17..c35
            @(negedge clk);
            if (bif.eng_start === 1'b1) cnt++;
        end
        checks++; if (cnt != 0) begin errors++; $display("FAIL pend_extra_frames: got %0d want 0", cnt); end
        checks++; if (bif.frame_cnt !== 16'd2) begin errors++; $display("FAIL pend_frame_cnt: got %0d want 2", bif.frame_cnt); end
    endtask

    task automatic test_coincide();
        int cnt;
        eng_lat  = 3;
        eng_word = 8'h4D;
        apply_reset();
        repeat (19) @(negedge clk);                      // c19: refresh due
        bif.data_out = 8'h99;
        bif.wr_req   = 1'b1;
        @(negedge clk);                                  // c20
        bif.wr_req = 1'b0;
        checks++; if (bif.eng_start !== 1'b1) begin errors++; $display("FAIL coin_start: got %b want 1", bif.eng_start); end
        checks++; if (bif.eng_out !== 8'h99) begin errors++; $display("FAIL coin_eng_out: got %h want 99", bif.eng_out); end
        cnt = 0;
        repeat (19) begin                                // c21..c39
            @(negedge clk);
            if (bif.eng_start === 1'b1) cnt++;
        end
        checks++; if (cnt != 0) begin errors++; $display("FAIL coin_double_start: got %0d want 0", cnt); end
        @(negedge clk);                                  // c40
        checks++; if (bif.eng_start !== 1'b1) begin errors++; $display("FAIL coin_next_refresh: got %b want 1", bif.eng_start); end
        checks++; if (bif.frame_cnt !== 16'd1) begin errors++; $display("FAIL coin_frame_cnt: got %0d want 1", bif.frame_cnt); end
        checks++; if (bif.data_in !== 8'h4D) begin errors++; $display("FAIL coin_data_in: got %h want 4d", bif.data_in); end
    endtask

    task automatic test_stray_done();
        int n;
        eng_lat  = 3;
        eng_word = 8'hEE;
        apply_reset();
        repeat (2) @(negedge clk);                       // c2: done while IDLE
        stray_done = 1'b1;
        @(negedge clk);                                  // c3
        stray_done = 1'b0;
        checks++; if (bif.in_valid !== 1'b0 || bif.data_in !== 8'h00) begin errors++; $display("FAIL stray_idle: got valid=%b data=%h want 0/00", bif.in_valid, bif.data_in); end
        checks++; if (bif.frame_cnt !== 16'd0) begin errors++; $display("FAIL stray_idle_cnt: got %0d want 0", bif.frame_cnt); end
        bif.data_out = 8'h33;
        bif.wr_req   = 1'b1;
        @(negedge clk);                                  // c4: START, done again
        bif.wr_req = 1'b0;
        stray_done = 1'b1;
        @(negedge clk);                                  // c5
        stray_done = 1'b0;
        eng_word   = 8'h42;
        checks++; if (bif.in_valid !== 1'b0 || bif.busy !== 1'b1) begin errors++; $display("FAIL stray_start: got valid=%b busy=%b want 0/1", bif.in_valid, bif.busy); end
        wait_valid(10, n);                               // real done c7, valid c8
        checks++; if (n != 3) begin errors++; $display("FAIL stray_real_lat: got %0d want 3", n); end
        checks++; if (bif.data_in !== 8'h42 || bif.frame_cnt !== 16'd1) begin errors++; $display("FAIL stray_real_data: got %h/%0d want 42/1", bif.data_in, bif.frame_cnt); end
    endtask

    task automatic test_watchdog();
        int n;
        eng_lat  = 3;
        eng_word = 8'h5C;
        apply_reset();
        eng_hang = 1'b1;
        repeat (2) @(negedge clk);                       // c2
        bif.data_out = 8'h11;
        bif.wr_req   = 1'b1;
        @(negedge clk);                                  // c3 = eng_start
        bif.wr_req = 1'b0;
        checks++; if (bif.eng_start !== 1'b1) begin errors++; $display("FAIL wd_start: got %b want 1", bif.eng_start); end
`ifdef SHIFTREG_WATCHDOG_EN
        repeat (49) @(negedge clk);                      // c52
        bif.err_clr = 1'b1;
        @(negedge clk);                                  // c53
        checks++; if (bif.err_timeout !== 1'b0 || bif.busy !== 1'b1) begin errors++; $display("FAIL wd_early: got err=%b busy=%b want 0/1", bif.err_timeout, bif.busy); end
        @(negedge clk);                                  // c54 = start+51
        bif.err_clr = 1'b0;
        eng_hang    = 1'b0;
        checks++; if (bif.err_timeout !== 1'b1) begin errors++; $display("FAIL wd_set_wins: got %b want 1", bif.err_timeout); end
        checks++; if (bif.busy !== 1'b0 || bif.in_valid !== 1'b0) begin errors++; $display("FAIL wd_abort: got busy=%b valid=%b want 0/0", bif.busy, bif.in_valid); end
        checks++; if (bif.data_in !== 8'h00 || bif.frame_cnt !== 16'd0) begin errors++; $display("FAIL wd_no_latch: got %h/%0d want 00/0", bif.data_in, bif.frame_cnt); end
        @(negedge clk);                                  // c55: overdue refresh
        checks++; if (bif.eng_start !== 1'b1) begin errors++; $display("FAIL wd_next_frame: got %b want 1", bif.eng_start); end
        wait_valid(10, n);
        checks++; if (n != 4 || bif.data_in !== 8'h5C || bif.frame_cnt !== 16'd1) begin errors++; $display("FAIL wd_next_data: got n=%0d %h/%0d want 4 5c/1", n, bif.data_in, bif.frame_cnt); end
        checks++; if (bif.err_timeout !== 1'b1) begin errors++; $display("FAIL wd_sticky: got %b want 1", bif.err_timeout); end
        bif.err_clr = 1'b1;
        @(negedge clk);
        bif.err_clr = 1'b0;
        checks++; if (bif.err_timeout !== 1'b0) begin errors++; $display("FAIL wd_clear: got %b want 0", bif.err_timeout); end
`else
        bif.err_clr = 1'b1;
        repeat (80) @(negedge clk);
        bif.err_clr = 1'b0;
        checks++; if (bif.err_timeout !== 1'b0) begin errors++; $display("FAIL nowd_err: got %b want 0", bif.err_timeout); end
        checks++; if (bif.busy !== 1'b1 || bif.frame_cnt !== 16'd0) begin errors++; $display("FAIL nowd_hold: got busy=%b cnt=%0d want 1/0", bif.busy, bif.frame_cnt); end
        stray_done = 1'b1;
        @(negedge clk);
        stray_done = 1'b0;
        checks++; if (bif.in_valid !== 1'b1 || bif.data_in !== 8'h5C || bif.frame_cnt !== 16'd1) begin errors++; $display("FAIL nowd_late_done: got %b %h/%0d want 1 5c/1", bif.in_valid, bif.data_in, bif.frame_cnt); end
        n = 0;
`endif
    endtask

    task automatic test_reset_mid();
        int n;
        int cnt;
        eng_lat  = 3;
        eng_word = 8'h3C;
        apply_reset();
        repeat (2) @(negedge clk);                       // c2
        bif.data_out = 8'h66;
        bif.wr_req   = 1'b1;
        @(negedge clk);                                  // c3
        bif.wr_req = 1'b0;
        wait_valid(10, n);                               // c7
        checks++; if (n != 4 || bif.frame_cnt !== 16'd1) begin errors++; $display("FAIL rmid_first: got n=%0d cnt=%0d want 4/1", n, bif.frame_cnt); end
        @(negedge clk);                                  // c8 IDLE
        bif.data_out = 8'h67;
        bif.wr_req   = 1'b1;
        @(negedge clk);                                  // c9 START
        bif.wr_req = 1'b0;
        @(negedge clk);                                  // c10 WAIT
        rst_n = 1'b0;
        #1;
        checks++; if (bif.busy !== 1'b0 || bif.eng_out !== 8'h00 || bif.eng_start !== 1'b0) begin errors++; $display("FAIL rmid_ctrl: got busy=%b out=%h start=%b want 0", bif.busy, bif.eng_out, bif.eng_start); end
        checks++; if (bif.data_in !== 8'h00 || bif.frame_cnt !== 16'd0 || bif.in_valid !== 1'b0) begin errors++; $display("FAIL rmid_data: got %h/%0d/%b want 0", bif.data_in, bif.frame_cnt, bif.in_valid); end
        @(negedge clk);
        rst_n = 1'b1;                                    // r0
        cnt = 0;
        repeat (15) begin
            @(negedge clk);
            if (bif.eng_start === 1'b1 || bif.in_valid === 1'b1) cnt++;
        end
        checks++; if (cnt != 0) begin errors++; $display("FAIL rmid_no_restart: got %0d want 0", cnt); end
        bif.data_out = 8'h12;
        bif.wr_req   = 1'b1;
        @(negedge clk);
        bif.wr_req = 1'b0;
        checks++; if (bif.eng_start !== 1'b1 || bif.eng_out !== 8'h12) begin errors++; $display("FAIL rmid_new_trigger: got %b/%h want 1/12", bif.eng_start, bif.eng_out); end
    endtask

    task automatic test_wrap();
        int n;
        eng_lat  = 3;
        eng_word = 8'hB7;
        apply_reset();
        repeat (2) @(negedge clk);                       // c2
        force dut.frame_cnt_q = 16'hFFFF;
        @(negedge clk);                                  // c3
        release dut.frame_cnt_q;
        bif.data_out = 8'h01;
        bif.wr_req   = 1'b1;
        @(negedge clk);                                  // c4 start
        bif.wr_req = 1'b0;
        wait_valid(10, n);                               // c8
        checks++; if (n != 4 || bif.frame_cnt !== 16'h0000) begin errors++; $display("FAIL wrap_cnt: got n=%0d cnt=%h want 4/0000", n, bif.frame_cnt); end
        checks++; if (bif.data_in !== 8'hB7) begin errors++; $display("FAIL wrap_data_in: got %h want b7", bif.data_in); end
    endtask

    initial begin
        rst_n        = 1'b0;
        bif.data_out = '0;
        bif.wr_req   = 1'b0;
        bif.err_clr  = 1'b0;
        stray_done   = 1'b0;
        eng_hang     = 1'b0;
        eng_lat      = 10;
        eng_word     = '0;
        test_reset();
        test_refresh();
        test_write();
        test_pending_back_to_back();
        test_coincide();
        test_stray_done();
        test_watchdog();
        test_reset_mid();
        test_wrap();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: run did not complete, errors=%0d", errors);
        $fatal(1, "timeout");
    end

endmodule
